// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared feeder state encoding and control-width derivation
package mem_if_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Rotation control needs log2(lanes) bits; lane counts are powers of two >= 2
    function automatic int ctrl_width(input int num_data);
        return (num_data > 1) ? $clog2(num_data) : 1;
    endfunction

endpackage

// File: rtl/feeder_fifo.sv
// rtl/feeder_fifo.sv - two-entry ordered buffer between the read port and the shifter load
module feeder_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign do_pop  = pop && !empty;
    // A push into a full buffer is legal when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/shifter_feeder.sv
// rtl/shifter_feeder.sv - burst feeder presenting buffered read beats and a rotation amount to a lane shifter
// Optional 32-bit STALL_CNT output enabled by defining SHIFTER_FEEDER_STALL_CNT_EN
module shifter_feeder
    import mem_if_pkg::*;
#(
    parameter  int DATA_WIDTH         = 16,
    parameter  int NUM_DATA           = 16,
    parameter  int LEN_WIDTH          = 8,
    localparam int SHUFFLE_DATA_WIDTH = DATA_WIDTH * NUM_DATA,
    localparam int CTRL_WIDTH         = ctrl_width(NUM_DATA)
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          CMD_VALID,
    output logic                          CMD_READY,
    input  logic [CTRL_WIDTH-1:0]         CMD_LANE,
    input  logic [LEN_WIDTH-1:0]          CMD_LEN,
    input  logic                          RDATA_VALID,
    output logic                          RDATA_READY,
    input  logic [SHUFFLE_DATA_WIDTH-1:0] RDATA,
    input  logic                          OUT_READY,
    output logic                          RD_EN,
    output logic [SHUFFLE_DATA_WIDTH-1:0] DATA_OUT,
    output logic [CTRL_WIDTH-1:0]         CTRL_OUT,
    output logic                          SHIFT_VALID,
    output logic                          DONE
`ifdef SHIFTER_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]                   STALL_CNT
`endif
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

    logic [0:0]            state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  acc_cnt_q, acc_cnt_d;
    logic [LEN_WIDTH-1:0]  iss_cnt_q, iss_cnt_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic                  done_q, done_d;
    logic                  shift_valid_q;

    logic cmd_fire;
    logic is_active;
    logic beat_push;
    logic last_pop;
    logic fifo_full;
    logic fifo_empty;

    assign is_active   = (state_q == ST_ACTIVE);
    assign CMD_READY   = (state_q == ST_IDLE);
    assign cmd_fire    = CMD_VALID && CMD_READY;
    assign RDATA_READY = is_active && !fifo_full && (acc_cnt_q < len_q);
    assign beat_push   = RDATA_VALID && RDATA_READY;
    assign RD_EN       = is_active && !fifo_empty && OUT_READY;
    // len_q is nonzero whenever ACTIVE, so len_q-1 cannot wrap
    assign last_pop    = RD_EN && (iss_cnt_q == len_q - LEN_ONE);

    assign CTRL_OUT    = ctrl_q;
    assign SHIFT_VALID = shift_valid_q;
    assign DONE        = done_q;

    feeder_fifo #(
        .WIDTH (SHUFFLE_DATA_WIDTH)
    ) u_fifo (
        .clk   (ACLK),
        .rst   (ARESET),
        .push  (beat_push),
        .wdata (RDATA),
        .pop   (RD_EN),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (DATA_OUT)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        acc_cnt_d = acc_cnt_q;
        iss_cnt_d = iss_cnt_q;
        ctrl_d    = ctrl_q;
        done_d    = 1'b0;
        if (cmd_fire) begin
            len_d     = CMD_LEN;
            ctrl_d    = CMD_LANE;
            acc_cnt_d = '0;
            iss_cnt_d = '0;
            if (CMD_LEN != '0) begin
                state_d = ST_ACTIVE;
            end else begin
                done_d = 1'b1;
            end
        end else begin
            if (beat_push) acc_cnt_d = acc_cnt_q + LEN_ONE;
            if (RD_EN)     iss_cnt_d = iss_cnt_q + LEN_ONE;
            if (last_pop) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            acc_cnt_q     <= '0;
            iss_cnt_q     <= '0;
            ctrl_q        <= '0;
            done_q        <= 1'b0;
            shift_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            acc_cnt_q     <= acc_cnt_d;
            iss_cnt_q     <= iss_cnt_d;
            ctrl_q        <= ctrl_d;
            done_q        <= done_d;
            shift_valid_q <= RD_EN;
        end
    end

`ifdef SHIFTER_FEEDER_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cmd_fire) begin
            stall_cnt_d = '0;
        end else if (is_active && !fifo_empty && !OUT_READY && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_shifter_feeder.sv
// tb/tb_shifter_feeder.sv - table-driven and directed-sequence bench for shifter_feeder
module tb_shifter_feeder;

    localparam int DW = 16;
    localparam int N  = 16;
    localparam int LW = 8;
    localparam int CW = 4;
    localparam int W  = DW * N;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic [CW-1:0] CMD_LANE;
    logic [LW-1:0] CMD_LEN;
    logic          RDATA_VALID;
    logic          RDATA_READY;
    logic [W-1:0]  RDATA;
    logic          OUT_READY;
    logic          RD_EN;
    logic [W-1:0]  DATA_OUT;
    logic [CW-1:0] CTRL_OUT;
    logic          SHIFT_VALID;
    logic          DONE;
`ifdef SHIFTER_FEEDER_STALL_CNT_EN
    logic [31:0]   STALL_CNT;
`endif

    shifter_feeder dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .CMD_VALID   (CMD_VALID),
        .CMD_READY   (CMD_READY),
        .CMD_LANE    (CMD_LANE),
        .CMD_LEN     (CMD_LEN),
        .RDATA_VALID (RDATA_VALID),
        .RDATA_READY (RDATA_READY),
        .RDATA       (RDATA),
        .OUT_READY   (OUT_READY),
        .RD_EN       (RD_EN),
        .DATA_OUT    (DATA_OUT),
        .CTRL_OUT    (CTRL_OUT),
        .SHIFT_VALID (SHIFT_VALID),
        .DONE        (DONE)
`ifdef SHIFTER_FEEDER_STALL_CNT_EN
        ,
        .STALL_CNT   (STALL_CNT)
`endif
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int lane;
        int len;
        int mode;
        bit idx_pat;
        int exp_pops;
        int exp_dones;
        int exp_l0;
        int exp_l15;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic prev_rden = 1'b0;

    logic [W-1:0]  src[$];
    int            src_idx;
    bit            src_rand;
    int            acc_cyc[$];
    int            done_cyc[$];
    int            rden_cyc[$];
    int            beat_acc_cyc[$];
    logic [W-1:0]  popped[$];
    logic [CW-1:0] pop_ctrl[$];
    int            rdr_seen;

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] idx_beat();
        logic [W-1:0] b;
        for (int j = 0; j < N; j++) b[j*DW +: DW] = DW'(j);
        return b;
    endfunction

    function automatic logic [W-1:0] tag_beat(input int k);
        logic [W-1:0] b;
        for (int j = 0; j < N; j++) b[j*DW +: DW] = {8'(k), 8'(j)};
        return b;
    endfunction

    // Shifter model: output lane i takes input lane (i + ctrl) mod N
    function automatic int rot_lane(input logic [W-1:0] b, input logic [CW-1:0] c, input int i);
        return int'(b[((i + int'(c)) % N)*DW +: DW]);
    endfunction

    task automatic drive_src();
        if (src_idx < src.size()) begin
            RDATA       = src[src_idx];
            RDATA_VALID = src_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end else begin
            RDATA       = '0;
            RDATA_VALID = 1'b0;
        end
    endtask

    task automatic clear_logs();
        acc_cyc.delete();
        done_cyc.delete();
        rden_cyc.delete();
        beat_acc_cyc.delete();
        popped.delete();
        pop_ctrl.delete();
        rdr_seen = 0;
    endtask

    task automatic cycle();
        logic fire;
        @(negedge ACLK);
        fire = RDATA_VALID && RDATA_READY;
        if (CMD_VALID && CMD_READY) acc_cyc.push_back(cyc);
        if (DONE) done_cyc.push_back(cyc);
        if (RD_EN) begin
            rden_cyc.push_back(cyc);
            popped.push_back(DATA_OUT);
            pop_ctrl.push_back(CTRL_OUT);
        end
        if (fire) beat_acc_cyc.push_back(cyc);
        if (RDATA_READY) rdr_seen++;
        chk_int("shift_valid", int'(SHIFT_VALID), ARESET ? 0 : int'(prev_rden));
        chk_int("rdata_ready_in_idle", int'(RDATA_READY && CMD_READY), 0);
        prev_rden = ARESET ? 1'b0 : RD_EN;
        cyc++;
        @(posedge ACLK);
        #1;
        if (fire) src_idx++;
        drive_src();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_int({tag, "_cmd_ready"},   int'(CMD_READY),   1);
        chk_int({tag, "_rdata_ready"}, int'(RDATA_READY), 0);
        chk_int({tag, "_rd_en"},       int'(RD_EN),       0);
        chk_int({tag, "_shift_valid"}, int'(SHIFT_VALID), 0);
        chk_int({tag, "_done"},        int'(DONE),        0);
        chk_vec({tag, "_data_out"},    DATA_OUT,          '0);
        chk_int({tag, "_ctrl_out"},    int'(CTRL_OUT),    0);
`ifdef SHIFTER_FEEDER_STALL_CNT_EN
        chk_int({tag, "_stall_cnt"},   int'(STALL_CNT),   0);
`endif
    endtask

    task automatic load_src(input int len, input bit idx_pat);
        src.delete();
        for (int k = 0; k < len; k++) src.push_back(idx_pat ? idx_beat() : tag_beat(k));
        src_idx = 0;
    endtask

    // mode 0: OUT_READY high, 1: random valid/ready, 2: six-cycle OUT_READY stall after first pop
    task automatic run_burst(input int lane, input int len, input int mode, input bit idx_pat);
        int guard;
        int stall_n;
        bit stall_checked;
        clear_logs();
        load_src(len, idx_pat);
        src_rand  = (mode == 1);
        drive_src();
        CMD_LANE  = CW'(lane);
        CMD_LEN   = LW'(len);
        CMD_VALID = 1'b1;
        OUT_READY = 1'b1;
        guard = 0;
        while (acc_cyc.size() == 0 && guard < 20) begin
            cycle();
            guard++;
        end
        CMD_VALID = 1'b0;
        guard = 0;
        stall_n = 0;
        stall_checked = 1'b0;
        while (done_cyc.size() == 0 && guard < 5000) begin
            if (mode == 1) begin
                OUT_READY = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                if (rden_cyc.size() == 1 && stall_n < 6) begin
                    OUT_READY = 1'b0;
                    stall_n++;
                end else begin
                    if (stall_n == 6 && !stall_checked) begin
                        chk_int("stall_rdata_ready_low", int'(RDATA_READY), 0);
                        chk_int("stall_beats_taken", beat_acc_cyc.size(), 3);
                        chk_vec("stall_head", DATA_OUT, src[1]);
                        stall_checked = 1'b1;
                    end
                    OUT_READY = 1'b1;
                end
            end
            cycle();
            guard++;
        end
        OUT_READY = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic check_burst(input string nm, input int lane, input int exp_pops, input int exp_dones,
                               input int exp_l0, input int exp_l15, input bit strict_lat);
        int bad;
        chk_int({nm, "_pops"}, popped.size(), exp_pops);
        for (int k = 0; k < popped.size() && k < src.size(); k++)
            chk_vec($sformatf("%s_beat%0d", nm, k), popped[k], src[k]);
        bad = 0;
        foreach (pop_ctrl[k]) if (int'(pop_ctrl[k]) != lane) bad++;
        chk_int({nm, "_ctrl_bad"}, bad, 0);
        chk_int({nm, "_dones"}, done_cyc.size(), exp_dones);
        if (exp_l0 >= 0 && popped.size() > 0) begin
            chk_int({nm, "_lane0"},  rot_lane(popped[0], pop_ctrl[0], 0),  exp_l0);
            chk_int({nm, "_lane15"}, rot_lane(popped[0], pop_ctrl[0], 15), exp_l15);
        end
        if (done_cyc.size() > 0 && acc_cyc.size() > 0) begin
            if (exp_pops == 0)
                chk_int({nm, "_done_lat"}, done_cyc[0] - acc_cyc[0], 1);
            else if (rden_cyc.size() > 0)
                chk_int({nm, "_done_after_last"}, done_cyc[0] - rden_cyc[rden_cyc.size()-1], 1);
        end
        if (exp_pops == 0) chk_int({nm, "_rdata_ready_seen"}, rdr_seen, 0);
        if (strict_lat && acc_cyc.size() > 0 && beat_acc_cyc.size() > 0 && rden_cyc.size() > 0) begin
            chk_int({nm, "_beat_lat"}, beat_acc_cyc[0] - acc_cyc[0], 1);
            chk_int({nm, "_rden_lat"}, rden_cyc[0] - beat_acc_cyc[0], 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   guard;

        vecs[0] = '{lane: 3,  len: 4,   mode: 0, idx_pat: 1'b1, exp_pops: 4,   exp_dones: 1, exp_l0: 3,  exp_l15: 2};
        vecs[1] = '{lane: 0,  len: 0,   mode: 0, idx_pat: 1'b0, exp_pops: 0,   exp_dones: 1, exp_l0: -1, exp_l15: -1};
        vecs[2] = '{lane: 7,  len: 1,   mode: 0, idx_pat: 1'b1, exp_pops: 1,   exp_dones: 1, exp_l0: 7,  exp_l15: 6};
        vecs[3] = '{lane: 15, len: 3,   mode: 1, idx_pat: 1'b1, exp_pops: 3,   exp_dones: 1, exp_l0: 15, exp_l15: 14};
        vecs[4] = '{lane: 0,  len: 2,   mode: 0, idx_pat: 1'b1, exp_pops: 2,   exp_dones: 1, exp_l0: 0,  exp_l15: 15};
        vecs[5] = '{lane: 5,  len: 255, mode: 1, idx_pat: 1'b0, exp_pops: 255, exp_dones: 1, exp_l0: -1, exp_l15: -1};

        ARESET      = 1'b1;
        CMD_VALID   = 1'b0;
        CMD_LANE    = '0;
        CMD_LEN     = '0;
        RDATA_VALID = 1'b0;
        RDATA       = '0;
        OUT_READY   = 1'b1;
        src_idx     = 0;
        src_rand    = 1'b0;
        clear_logs();
        #1;
        check_reset_outputs("init");
        repeat (2) cycle();
        ARESET = 1'b0;
        cycle();

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i].lane, vecs[i].len, vecs[i].mode, vecs[i].idx_pat);
            check_burst($sformatf("v%0d", i), vecs[i].lane, vecs[i].exp_pops, vecs[i].exp_dones,
                        vecs[i].exp_l0, vecs[i].exp_l15, vecs[i].mode == 0);
        end

        // Backpressure: two beats buffered, then the rest drain in order
        run_burst(1, 5, 2, 1'b0);
        check_burst("stall", 1, 5, 1, -1, -1, 1'b1);
        chk_int("stall_beats_total", beat_acc_cyc.size(), 5);
`ifdef SHIFTER_FEEDER_STALL_CNT_EN
        chk_int("stall_cnt", int'(STALL_CNT), 6);
`endif

        // CMD_VALID held: second command lands exactly in the first DONE cycle
        clear_logs();
        load_src(4, 1'b0);
        src_rand = 1'b0;
        drive_src();
        CMD_LANE  = 4'd2;
        CMD_LEN   = 8'd2;
        CMD_VALID = 1'b1;
        OUT_READY = 1'b1;
        guard = 0;
        while (acc_cyc.size() < 2 && guard < 200) begin
            cycle();
            guard++;
        end
        CMD_VALID = 1'b0;
        chk_int("hold_accepts", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2 && done_cyc.size() > 0)
            chk_int("hold_second_accept_cycle", acc_cyc[1], done_cyc[0]);
        guard = 0;
        while (done_cyc.size() < 2 && guard < 200) begin
            cycle();
            guard++;
        end
        chk_int("hold_dones", done_cyc.size(), 2);
        chk_int("hold_pops", popped.size(), 4);
        for (int k = 0; k < popped.size() && k < 4; k++)
            chk_vec($sformatf("hold_beat%0d", k), popped[k], src[k]);

        // Reset after two of four beats: immediate reset outputs, no DONE, then a clean burst
        clear_logs();
        load_src(4, 1'b0);
        drive_src();
        CMD_LANE  = 4'd6;
        CMD_LEN   = 8'd4;
        CMD_VALID = 1'b1;
        guard = 0;
        while (acc_cyc.size() == 0 && guard < 20) begin
            cycle();
            guard++;
        end
        CMD_VALID = 1'b0;
        guard = 0;
        while (rden_cyc.size() < 2 && guard < 50) begin
            cycle();
            guard++;
        end
        chk_int("rst_pops_before", rden_cyc.size(), 2);
        ARESET = 1'b1;
        #1;
        check_reset_outputs("midrst");
        cycle();
        ARESET = 1'b0;
        repeat (4) cycle();
        chk_int("rst_no_done", done_cyc.size(), 0);
        run_burst(4, 1, 0, 1'b0);
        check_burst("after_rst", 4, 1, 1, -1, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shifter_feeder.md
SHIFTER_FEEDER -- requirements
Module: shifter_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, lane width in bits.
REQ-002 Parameter NUM_DATA, default 16, lanes per beat; power of two, at least 2.
REQ-003 Parameter LEN_WIDTH, default 8, width of the burst-length field.
REQ-004 Derived widths: SHUFFLE_DATA_WIDTH = DATA_WIDTH*NUM_DATA; CTRL_WIDTH = log2(NUM_DATA).
REQ-005 ACLK  in  1  single clock; all state updates on the rising edge.
REQ-006 ARESET  in  1  asynchronous, active-high reset.
REQ-007 CMD_VALID / CMD_READY  in / out  1  burst command handshake.
REQ-008 CMD_LANE  in  CTRL_WIDTH  lane offset of the first valid element in each beat.
REQ-009 CMD_LEN  in  LEN_WIDTH  number of beats in the burst.
REQ-010 RDATA_VALID / RDATA_READY  in / out  1  memory read-beat handshake.
REQ-011 RDATA  in  SHUFFLE_DATA_WIDTH  read beat; lane k is bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 OUT_READY  in  1  downstream consumer can accept one aligned beat.
REQ-013 RD_EN  out  1  load strobe to the shifter.
REQ-014 DATA_OUT  out  SHUFFLE_DATA_WIDTH  beat presented to the shifter.
REQ-015 CTRL_OUT  out  CTRL_WIDTH  rotation amount to the shifter.
REQ-016 SHIFT_VALID  out  1  shifter output is valid in this cycle.
REQ-017 DONE  out  1  one-cycle pulse at burst completion.

Function
REQ-018 States: IDLE and ACTIVE.
REQ-019 CMD_READY is high only in IDLE.
REQ-020 A command is accepted when CMD_VALID and CMD_READY are both high. On acceptance the block latches CMD_LANE into CTRL_OUT, latches CMD_LEN, and clears both beat counters.
REQ-021 An accepted command with CMD_LEN=0 stays in IDLE and pulses DONE in the next cycle. It produces no RDATA_READY and no RD_EN.
REQ-022 An accepted command with CMD_LEN>0 moves to ACTIVE in the next cycle.
REQ-023 RDATA_READY = ACTIVE and FIFO not full and accepted count < length.
REQ-024 RDATA_READY is never high in IDLE.
REQ-025 Accepted beats are written into a 2-entry FIFO, preserving order.
REQ-026 A simultaneous write to a full FIFO and read from it is permitted; occupancy stays unchanged.
REQ-027 RD_EN = ACTIVE and FIFO not empty and OUT_READY. On RD_EN the FIFO pops and the issued count increments.
REQ-028 DATA_OUT is the FIFO head, combinational; it is all zeros when the FIFO is empty.
REQ-029 CTRL_OUT is constant for the whole burst. Output lane i of the shifter equals input lane (i+CTRL_OUT) mod NUM_DATA.
REQ-030 SHIFT_VALID is RD_EN registered by one cycle, matching the shifter's input-register latency.
REQ-031 Minimum latency: beat accepted in cycle t; RD_EN in cycle t+1; SHIFT_VALID in cycle t+2.
REQ-032 When RD_EN pops the final beat (issued count reaches length), the block returns to IDLE next cycle and DONE pulses in that same cycle.
REQ-033 The next command can be accepted no earlier than that IDLE cycle.
REQ-034 Counters are LEN_WIDTH bits. A length of 2^LEN_WIDTH-1 must complete without wrap-around.
REQ-035 If OUT_READY is low, the FIFO holds its contents and RDATA_READY falls once the FIFO is full. No beat is dropped or duplicated.

Reset
REQ-036 ARESET forces IDLE, an empty FIFO, and zeroed counters. It takes effect immediately, including in the middle of a burst.
REQ-037 Output values during reset: CMD_READY=1; RDATA_READY=0; RD_EN=0; SHIFT_VALID=0; DONE=0; DATA_OUT=0; CTRL_OUT=0.
REQ-038 A burst interrupted by reset is abandoned; no DONE is generated for it.

Configuration
REQ-039 Macro SHIFTER_FEEDER_STALL_CNT_EN.
REQ-040 When SHIFTER_FEEDER_STALL_CNT_EN is defined, a 32-bit STALL_CNT output counts ACTIVE cycles in which the FIFO is non-empty and OUT_READY is low. The counter saturates at all ones, clears on command acceptance and clears on reset.
REQ-041 When SHIFTER_FEEDER_STALL_CNT_EN is undefined, STALL_CNT and its logic are absent; all other behaviour is identical.

Structure
REQ-042 A shared package mem_if_pkg holds the state encoding (IDLE, ACTIVE) and the CTRL_WIDTH derivation.
REQ-043 The 2-entry FIFO is a sub-module named feeder_fifo (parameter WIDTH; ports push, pop, full, empty, head).

Verification
REQ-044 CMD_LANE=3, CMD_LEN=4, RDATA lanes equal to their lane index, OUT_READY=1 -> 4 RD_EN pulses; shifter output lane 0 = 3 and lane 15 = 2; a single DONE pulse.
REQ-045 CMD_LEN=0 -> DONE one cycle after acceptance; RD_EN never high.
REQ-046 CMD_LEN=5, OUT_READY low for 6 cycles mid-burst -> RDATA_READY low after 2 buffered beats; all 5 beats issued in order; STALL_CNT=6 when enabled.
REQ-047 CMD_VALID held high through a burst -> next command accepted in the DONE cycle, not earlier.
REQ-048 ARESET asserted after 2 of 4 beats -> all outputs at reset values in the same cycle; no DONE; a fresh CMD_LEN=1 burst then completes normally.
REQ-049 CMD_LEN=255 with random RDATA_VALID and OUT_READY -> exactly 255 RD_EN pulses, in order, then DONE.
